gpio_input_conditioner: RTL and testbench
=========================================

Name: gpio_input_conditioner

Overview:
Per-pin input conditioning stage between the GPIO pads and the GPIO controller's gpio_in_data input inside the GPIO subsystem. Its functions, per pin:
- Synchronises asynchronous pad inputs into sys_clk.
- Optionally debounces each pin with a shared programmable stability window.
- Emits single-cycle rise/fall pulses for the controller's interrupt logic.

Parameters:
NUM_GPIO, 32, number of pins.
SYNC_STAGES, 2, synchroniser depth; legal values >= 2.
CNT_W, 16, debounce counter width; maximum window is 2^CNT_W - 1.

Ports:
sys_clk  in  1  system clock.
rst_n  in  1  reset.
gpio_pad_in  in  NUM_GPIO  raw asynchronous pad inputs.
debounce_en  in  NUM_GPIO  per-pin debounce enable; quasi-static, sys_clk domain.
debounce_limit  in  CNT_W  shared stability window L, in cycles; sys_clk domain.
gpio_in_data  out  NUM_GPIO  conditioned pin state, feeds the controller's gpio_in_data.
gpio_rise  out  NUM_GPIO  1-cycle pulse on a conditioned 0->1 transition.
gpio_fall  out  NUM_GPIO  1-cycle pulse on a conditioned 1->0 transition.

Behaviour:
- Reset: rst_n is asynchronous and active-low; the clock is sys_clk. All synchroniser flops, state registers, counters, gpio_in_data, gpio_rise and gpio_fall clear to 0. All outputs are registered.
- Synchroniser: SYNC_STAGES-deep flop chain per pin. Its last stage is s[i]. No logic sits between synchroniser stages.
- Per-pin state: conditioned state q[i] (drives gpio_in_data[i]) and counter cnt[i] of CNT_W bits.
- Bypass (debounce_en[i]=0):
  - q[i] <= s[i] every cycle; cnt[i] <= 0.
  - Latency from pad change to gpio_in_data is SYNC_STAGES+1 rising edges, counting the sampling edge.
- Debounce (debounce_en[i]=1), evaluated at each edge:
  - s[i]==q[i]: cnt[i] <= 0 (any glitch restarts the window).
  - s[i]!=q[i] and cnt[i] >= L: q[i] <= s[i], cnt[i] <= 0.
  - s[i]!=q[i] and cnt[i] < L: cnt[i] <= cnt[i]+1.
  - Net effect: s[i] must differ from q[i] for L+1 consecutive edges before it is accepted.
  - Pad-to-output latency is SYNC_STAGES+L+1 edges.
  - L=0 behaves identically to bypass.
- Counter never wraps. The >= compare bounds it at L, so L = 2^CNT_W - 1 is legal.
- debounce_limit change mid-count takes effect on the next edge. If the new L <= cnt, a pending change is accepted on that edge.
- debounce_en 1->0 mid-count: cnt cleared and bypass applies on that same edge. debounce_en 0->1 starts counting from 0.
- Edge pulses:
  - gpio_rise[i] and gpio_fall[i] are registered at the same edge that updates q[i].
  - gpio_rise[i] is 1 iff q[i] transitions 0->1 at that edge; gpio_fall[i] is 1 iff q[i] transitions 1->0.
  - Each pulse lasts exactly 1 cycle. Rise and fall are never both high on the same pin.
  - Back-to-back transitions in bypass give alternating pulses on consecutive cycles.
- Pins are fully independent. Any combination of pins may change or pulse in the same cycle.
- Reset release with a pad held high: q starts at 0. The pin therefore produces a gpio_rise pulse after the normal latency. This is required behaviour; software masks interrupts until it is initialised.
- Reset asserted mid-debounce: the count is discarded and no pulse is generated; the window restarts after release.
- No X-propagation: all flops are reset, and no combinational path runs from gpio_pad_in to any output.

Test Plan:
- Reset/bypass: hold rst_n low with pad[0]=1, then release; debounce_en=0, SYNC_STAGES=2 -> gpio_in_data[0] rises on the 3rd edge after release, and gpio_rise[0] is high for exactly that 1 cycle.
- Debounce accept: en[5]=1, L=3, pad[5] steps 0->1 and holds -> gpio_in_data[5]=1 exactly 6 edges after the sampling edge, with a single gpio_rise[5] pulse. Step back to 0 -> gpio_fall[5] fires after the same 6 edges.
- Glitch reject: en[5]=1, L=3, pad[5] high for 3 cycles then low -> gpio_in_data[5] stays 0 and no pulses occur. Repeat with 4 high cycles -> accepted.
- Limit change mid-count: L=100, pad steps, after cnt reaches 10 set L=5 -> q updates on the next edge.
- Saturation: CNT_W=4, L=15, stable change -> accepted after 16 edges with no wrap. L=0 with en=1 -> timing identical to bypass.
- Multi-pin and en toggle: all 32 pins toggle together in bypass -> 32 simultaneous rise pulses, then fall pulses. Clearing en mid-count on one pin -> that pin updates on the same edge.

Source files
------------

// File: rtl/gpio_input_conditioner.sv
// GPIO pad input conditioning: per-pin synchroniser, optional debounce with a
// shared stability window, and registered single-cycle rise/fall pulses.

module gpio_cond_pin #(
    parameter int CNT_W = 16
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             sync_in,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             data,
    output logic             rise,
    output logic             fall
);
    logic             q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        if (!en) begin
            q_d   = sync_in;
            cnt_d = '0;
        end else if (sync_in == q_q) begin
            cnt_d = '0;
        end else if (cnt_q >= limit) begin
            // >= rather than == so a lowered limit accepts immediately and the
            // counter can never run past the window and wrap.
            q_d   = sync_in;
            cnt_d = '0;
        end else begin
            cnt_d = CNT_W'(cnt_q + 1'b1);
        end
        rise_d = q_d & ~q_q;
        fall_d = ~q_d & q_q;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= 1'b0;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign data = q_q;
    assign rise = rise_q;
    assign fall = fall_q;
endmodule

module gpio_input_conditioner #(
    parameter int NUM_GPIO    = 32,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic [NUM_GPIO-1:0] gpio_pad_in,
    input  logic [NUM_GPIO-1:0] debounce_en,
    input  logic [CNT_W-1:0]    debounce_limit,
    output logic [NUM_GPIO-1:0] gpio_in_data,
    output logic [NUM_GPIO-1:0] gpio_rise,
    output logic [NUM_GPIO-1:0] gpio_fall
);
    // Plain flop chain, stage 0 samples the pad; nothing between stages.
    logic [SYNC_STAGES-1:0][NUM_GPIO-1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], gpio_pad_in};
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    for (genvar i = 0; i < NUM_GPIO; i++) begin : g_pin
        gpio_cond_pin #(.CNT_W(CNT_W)) u_pin (
            .sys_clk (sys_clk),
            .rst_n   (rst_n),
            .sync_in (sync_q[SYNC_STAGES-1][i]),
            .en      (debounce_en[i]),
            .limit   (debounce_limit),
            .data    (gpio_in_data[i]),
            .rise    (gpio_rise[i]),
            .fall    (gpio_fall[i])
        );
    end
endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Self-checking bench for gpio_input_conditioner: table-driven pulse scenarios
// through a scoreboard queue, plus hand-written multi-cycle corner cases.

module tb_gpio_input_conditioner;
    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic [31:0] pad     = '0;
    logic [31:0] en      = '0;
    logic [15:0] lim     = '0;
    logic [31:0] data, rise, fall;

    logic [1:0]  pad4 = '0;
    logic [1:0]  en4  = '0;
    logic [3:0]  lim4 = '0;
    logic [1:0]  data4, rise4, fall4;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    gpio_input_conditioner #(.NUM_GPIO(32), .SYNC_STAGES(2), .CNT_W(16)) u_dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .gpio_pad_in    (pad),
        .debounce_en    (en),
        .debounce_limit (lim),
        .gpio_in_data   (data),
        .gpio_rise      (rise),
        .gpio_fall      (fall)
    );

    gpio_input_conditioner #(.NUM_GPIO(2), .SYNC_STAGES(2), .CNT_W(4)) u_dut4 (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .gpio_pad_in    (pad4),
        .debounce_en    (en4),
        .debounce_limit (lim4),
        .gpio_in_data   (data4),
        .gpio_rise      (rise4),
        .gpio_fall      (fall4)
    );

    typedef struct {
        int   pin;
        logic en;
        int   lim;
        int   high;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] rise;
        logic [31:0] fall;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [31:0] d, input logic [31:0] r,
                           input logic [31:0] f);
        chk({name, ".data"}, data, d);
        chk({name, ".rise"}, rise, r);
        chk({name, ".fall"}, fall, f);
    endtask

    initial begin
        int   leff, win;
        logic acc;
        exp_t e;
        logic [31:0] bit_m;

        // Pad pin 5 high for `high` sampling edges starting at edge 1.
        // Effective window is L when enabled, 0 in bypass. Accepted iff
        // high >= L+1; q rises at edge L+3 and falls at edge high+L+3.
        vecs[0] = '{5, 1'b1, 3, 10};
        vecs[1] = '{5, 1'b1, 3, 3};
        vecs[2] = '{5, 1'b1, 3, 4};
        vecs[3] = '{5, 1'b0, 3, 1};
        vecs[4] = '{5, 1'b1, 0, 2};
        vecs[5] = '{0, 1'b1, 7, 8};
        vecs[6] = '{31, 1'b1, 1, 1};
        vecs[7] = '{31, 1'b0, 0, 5};
        vecs[8] = '{12, 1'b1, 2, 2};

        // Reset with pad[0] held high, bypass.
        pad[0] = 1'b1;
        repeat (3) tick();
        chk_all("reset", '0, '0, '0);
        chk("reset.dut4", {data4, rise4, fall4}, '0);
        rst_n = 1'b1;
        tick();
        chk_all("rel.e1", '0, '0, '0);
        tick();
        chk_all("rel.e2", '0, '0, '0);
        tick();
        chk_all("rel.e3", 32'h1, 32'h1, '0);
        tick();
        chk_all("rel.e4", 32'h1, '0, '0);
        pad[0] = 1'b0;
        repeat (4) tick();
        chk_all("rel.fall_done", '0, '0, '0);

        // Table-driven scenarios through the scoreboard.
        foreach (vecs[k]) begin
            bit_m = 32'h1 << vecs[k].pin;
            en    = vecs[k].en ? '1 : '0;
            lim   = 16'(vecs[k].lim);
            leff  = vecs[k].en ? vecs[k].lim : 0;
            acc   = (vecs[k].high >= leff + 1);
            win   = vecs[k].high + leff + 6;
            repeat (4) tick();
            for (int t = 1; t <= win; t++) begin
                pad = (t <= vecs[k].high) ? bit_m : '0;
                e.data = (acc && t >= leff + 3 && t < vecs[k].high + leff + 3) ? bit_m : '0;
                e.rise = (acc && t == leff + 3) ? bit_m : '0;
                e.fall = (acc && t == vecs[k].high + leff + 3) ? bit_m : '0;
                sb.push_back(e);
                tick();
                e = sb.pop_front();
                chk($sformatf("vec%0d.t%0d.data", k, t), data, e.data);
                chk($sformatf("vec%0d.t%0d.rise", k, t), rise, e.rise);
                chk($sformatf("vec%0d.t%0d.fall", k, t), fall, e.fall);
            end
        end
        pad = '0;
        en  = '0;
        repeat (4) tick();

        // Limit lowered mid-count: cnt reaches 10 after edge 12.
        en[5] = 1'b1;
        lim   = 16'd100;
        repeat (2) tick();
        pad[5] = 1'b1;
        repeat (12) tick();
        chk_all("limchg.e12", '0, '0, '0);
        lim = 16'd5;
        tick();
        chk_all("limchg.e13", 32'h20, 32'h20, '0);
        pad[5] = 1'b0;
        repeat (12) tick();
        chk_all("limchg.settle", '0, '0, '0);

        // Enable cleared mid-count: bypass applies on that same edge.
        en    = '0;
        en[7] = 1'b1;
        lim   = 16'd100;
        repeat (2) tick();
        pad[7] = 1'b1;
        repeat (12) tick();
        chk_all("entog.e12", '0, '0, '0);
        en[7] = 1'b0;
        tick();
        chk_all("entog.e13", 32'h80, 32'h80, '0);
        pad[7] = 1'b0;
        repeat (4) tick();
        chk_all("entog.settle", '0, '0, '0);

        // All pins toggle together in bypass.
        en  = '0;
        pad = '1;
        repeat (2) tick();
        chk_all("all.e2", '0, '0, '0);
        tick();
        chk_all("all.rise", '1, '1, '0);
        pad = '0;
        tick();
        chk_all("all.hold", '1, '0, '0);
        repeat (2) tick();
        chk_all("all.fall", '0, '0, '1);
        tick();
        chk_all("all.idle", '0, '0, '0);

        // Reset mid-debounce discards the count; window restarts on release.
        en[5]  = 1'b1;
        lim    = 16'd3;
        pad[5] = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk_all("rstmid.asserted", '0, '0, '0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk_all("rstmid.e5", '0, '0, '0);
        tick();
        chk_all("rstmid.e6", 32'h20, 32'h20, '0);
        pad[5] = 1'b0;
        repeat (8) tick();
        chk_all("rstmid.settle", '0, '0, '0);

        // Saturation on the 4-bit counter: L=15 accepted after 16 evaluations.
        en4  = 2'b01;
        lim4 = 4'd15;
        tick();
        pad4 = 2'b01;
        repeat (17) tick();
        chk("sat.e17", {30'd0, data4}, 32'h0);
        tick();
        chk("sat.e18.data", {30'd0, data4}, 32'h1);
        chk("sat.e18.rise", {30'd0, rise4}, 32'h1);
        tick();
        chk("sat.e19.rise", {30'd0, rise4}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
